serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: accepts one WIDTH-bit add request, then time-shares a single full-adder cell over WIDTH cycles, LSB first.
- Returns sum, carry-out and signed overflow through a valid/ready result port.
- Used where area matters more than throughput. Instantiates one fa cell (inputs a, b, cin; outputs sout, cout) as its only arithmetic.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  controller can accept a request (high only in IDLE)
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
cin  input  1  carry-in, sampled on accept
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; shift regs, carry flop, bit counter, sum, cout, ovf all 0; out_valid=0, busy=0, in_ready=1 once the FSM is in IDLE.
- Internal regs:
  - a_sr, b_sr: WIDTH bits each.
  - sum_sr: WIDTH bits.
  - carry: 1 bit.
  - cnt: clog2(WIDTH+1) bits.
  - msb_cin: 1 bit.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, sum_sr<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one bit per cycle:
  - fa inputs are a_sr[0], b_sr[0], carry.
  - sum_sr <= {sout, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right, zero fill.
  - carry <= fa cout; cnt <= cnt+1.
  - When cnt==WIDTH-1, latch msb_cin<=carry (carry into MSB) in the same cycle.
  - When cnt==WIDTH-1, go to DONE on that edge.
- DONE:
  - out_valid=1; sum=sum_sr, cout=carry, ovf=msb_cin^carry.
  - All outputs held stable while out_ready=0.
  - On out_ready, go to IDLE.
  - sum, cout and ovf keep their last values in IDLE; they are only meaningful while out_valid=1.
- Latency: accept edge E; out_valid rises after edge E+WIDTH, i.e. exactly WIDTH cycles after the accept.
- Throughput: one operation per WIDTH+2 cycles at best. The result hand-off edge returns the FSM to IDLE; the next accept happens no earlier than the following edge (no same-cycle accept in DONE).
- in_valid, a, b and cin are ignored outside IDLE; they need not be held after the accept.
- out_ready is ignored outside DONE.
- WIDTH=1: RUN lasts one cycle; msb_cin=cin; ovf=cin^cout.
- Reset asserted mid-RUN or in DONE: operation is discarded, all state cleared immediately, no result emitted. The first request after reset release computes correctly.
- in_valid held high across a completed operation: the next operation is accepted from IDLE with the operands present at that time.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset: hold rst_n low for 3 cycles, then release -> out_valid=0, busy=0, in_ready=1, sum=0x00, cout=0, ovf=0.
- WIDTH=8, a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, ovf=0. out_valid rises exactly 8 cycles after the accept edge; busy is high for those 8 cycles plus the DONE cycles.
- Carry/overflow corners, checked against the a+b+cin model:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
  - a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- Backpressure:
  - Setup: out_ready=0 for 5 cycles after out_valid rises, with in_valid=1, a=0x11, b=0x22 driven throughout.
  - While out_ready=0: in_ready stays 0 and the first result is stable every cycle.
  - On out_ready=1: the result is handed off in one cycle; 0x11+0x22 is accepted on the next edge and yields sum=0x33.
- Reset mid-operation: assert rst_n low 3 cycles into RUN of a=0xAA, b=0x55 -> all outputs 0 at once and state IDLE. After release, a=0x01, b=0x02 gives sum=0x03 after 8 cycles; the aborted result never appears.
- Random regression: 1000 random a, b, cin with random out_ready stalls -> every result matches the model, and result count equals accept count.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell is reused over WIDTH cycles, LSB first,
// with a valid/ready request port and a valid/ready result port.

module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sout,
    output logic cout
);
    assign sout = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic               msb_cin_q, msb_cin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_sout, fa_cout;
    logic [WIDTH-1:0]   sum_shift;

    fa u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sout (fa_sout),
        .cout (fa_cout)
    );

    // New sum bits enter at the MSB so the LSB-first result ends up in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = fa_sout;
        end else begin : g_wn
            assign sum_shift = {fa_sout, sum_sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                sum_sr_d = sum_shift;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Carry entering the MSB is needed for the signed-overflow flag.
                    msb_cin_d = carry_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_sr_q;
    assign cout      = carry_q;
    assign ovf       = msb_cin_q ^ carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl (WIDTH=8) against hand-computed and a+b+cin values.

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int results = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        cin = tc;
        step();
        in_valid = 1'b0;
        accepts++;
        chk("busy_after_accept", 64'(busy), 64'(1));
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            chk("busy_in_run", 64'(busy), 64'(1));
            step();
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input int stall, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        accept(ta, tb_, tc);
        wait_out(n);
        chk("latency", 64'(n), 64'(8));
        chk("sum", 64'(sum), 64'(es));
        chk("cout", 64'(cout), 64'(ec));
        chk("ovf", 64'(ovf), 64'(eo));
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            step();
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_sum", 64'(sum), 64'(es));
            chk("stall_busy", 64'(busy), 64'(1));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        results++;
        chk("valid_after_handoff", 64'(out_valid), 64'(0));
        chk("ready_after_handoff", 64'(in_ready), 64'(1));
    endtask

    initial begin
        int n;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rs;
        logic       ro;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));

        // Basic and carry/overflow corners
        run_op(8'h0F, 8'h01, 1'b0, 2, 8'h10, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0, 1'b0);

        // Backpressure with the next request already waiting
        accept(8'h05, 8'h03, 1'b0);
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
        cin = 1'b0;
        wait_out(n);
        chk("bp_latency", 64'(n), 64'(8));
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_sum", 64'(sum), 64'(8'h08));
            chk("bp_valid", 64'(out_valid), 64'(1));
            step();
        end
        chk("bp_sum_final", 64'(sum), 64'(8'h08));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        results++;
        chk("bp_handoff_valid", 64'(out_valid), 64'(0));
        chk("bp_handoff_in_ready", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        accepts++;
        chk("bp_next_accepted", 64'(busy), 64'(1));
        wait_out(n);
        chk("bp_next_latency", 64'(n), 64'(8));
        chk("bp_next_sum", 64'(sum), 64'(8'h33));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        results++;

        // Reset in the middle of an operation
        accept(8'hAA, 8'h55, 1'b0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_sum", 64'(sum), 64'(0));
        chk("mid_rst_cout", 64'(cout), 64'(0));
        chk("mid_rst_ovf", 64'(ovf), 64'(0));
        accepts--;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 64'(out_valid), 64'(0));
        run_op(8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0, 1'b0);

        // Random regression
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 9'(ra) + 9'(rb) + 9'(rc);
            ro = (ra[7] == rb[7]) && (rs[7] != ra[7]);
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), rs[7:0], rs[8], ro);
        end
        chk("result_count", 64'(results), 64'(accepts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
